regfile_dump: RTL and testbench

Debug readout engine for the MIPS single-cycle datapath's 32×32 register file: on a start pulse it walks every register index in order, reads each through a dedicated combinational read port, and streams `{index, value}` beats out over a valid/ready handshake. It replaces file-based dumping as the synthesizable way to observe architectural register state, for example feeding a UART or test bench. `busy` is exported so the top level can stall the PC and block register writes, giving a coherent snapshot.

---
 rtl/regfile_dump.sv | 109 ++++++++++
 tb/tb_regfile_dump.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// regfile_dump: walks every register index and streams {index,value}
// beats over valid/ready; busy lets the top level freeze the datapath.
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] Dump_Read_Register,
  input  logic [DATA_W-1:0] Dump_Read_Data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic last_q, last_d;
  logic valid_q, valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        ptr_d = '0;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        addr_d  = ptr_q;
        data_d  = Dump_Read_Data;
        last_d  = (ptr_q == LAST_IDX);
        state_d = S_SEND;
      end
      S_SEND: begin
        if (valid_q && dump_ready) begin
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        ptr_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Flag outputs follow the next state so they come straight off flops
    valid_d = (state_d == S_SEND);
    busy_d  = (state_d == S_FETCH) || (state_d == S_SEND);
    done_d  = (state_d == S_DONE);
  end

  assign Dump_Read_Register = (state_q == S_FETCH) ? ptr_q : '0;
  assign dump_valid = valid_q;
  assign dump_addr  = addr_q;
  assign dump_data  = data_q;
  assign dump_last  = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: timing table, randomized backpressure,
// restart, async reset, live writes and back-to-back dumps.
module tb_regfile_dump;
  localparam int N  = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic dump_ready = 1'b0;
  logic [AW-1:0] Dump_Read_Register, dump_addr;
  logic [DW-1:0] Dump_Read_Data, dump_data;
  logic dump_valid, dump_last, busy, done;

  logic [DW-1:0] rf [N];
  logic [DW-1:0] expv [N];

  int checks = 0;
  int errors = 0;

  regfile_dump #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .Dump_Read_Register(Dump_Read_Register),
    .Dump_Read_Data(Dump_Read_Data),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_addr(dump_addr),
    .dump_data(dump_data),
    .dump_last(dump_last),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  assign Dump_Read_Data = rf[Dump_Read_Register];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t got[$];
  int dones = 0;
  int stall_viol = 0;
  logic pv = 1'b0;
  beat_t pb;

  // Beat capture and hold-while-stalled observer
  always @(posedge clk) begin
    if (reset && dump_valid && dump_ready)
      got.push_back({dump_addr, dump_data, dump_last});
    if (reset && done) dones++;
    if (pv && reset &&
        !(dump_valid && {dump_addr, dump_data, dump_last} == pb))
      stall_viol++;
    pv = reset && dump_valid && !dump_ready;
    pb = {dump_addr, dump_data, dump_last};
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < N; i++) begin
      rf[i]   = 32'hA5A50000 + i;
      expv[i] = 32'hA5A50000 + i;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic check_beats(input string nm, input int reps);
    chk({nm, "_count"}, 64'(got.size()), 64'(N * reps));
    for (int i = 0; i < got.size() && i < N * reps; i++) begin
      chk($sformatf("%s[%0d]", nm, i),
          {got[i].a, got[i].l, got[i].d},
          {5'(i % N), (i % N) == N - 1, expv[i % N]});
    end
  endtask

  typedef struct {
    int          cyc;
    logic        busy;
    logic        valid;
    logic        last;
    logic        done;
    logic        rr_chk;
    logic [AW-1:0] rr;
  } vec_t;

  vec_t tv [8];
  int done_c[$];
  int rise_c[$];

  initial begin
    logic held7;
    int   hold;
    logic wrote;
    logic prev_busy;
    int   wr_idx [2];
    logic [DW-1:0] wr_val [2];

    tv[0] = '{1,  1, 0, 0, 0, 1, 5'd0};
    tv[1] = '{2,  1, 1, 0, 0, 0, 5'd0};
    tv[2] = '{3,  1, 0, 0, 0, 1, 5'd1};
    tv[3] = '{4,  1, 1, 0, 0, 0, 5'd0};
    tv[4] = '{63, 1, 0, 0, 0, 1, 5'd31};
    tv[5] = '{64, 1, 1, 1, 0, 0, 5'd0};
    tv[6] = '{65, 0, 0, 1, 1, 1, 5'd0};
    tv[7] = '{66, 0, 0, 1, 0, 1, 5'd0};

    preload();
    repeat (2) @(negedge clk);
    chk("reset_flags", {dump_valid, busy, done, dump_last}, 0);
    chk("reset_regs", {dump_addr, dump_data, Dump_Read_Register}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_flags", {dump_valid, busy, done}, 0);

    // Nominal dump with cycle-accurate timing table
    got.delete(); dones = 0; dump_ready = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 66; c++) begin
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (tv[k].cyc == c) begin
          chk($sformatf("tv_cyc%0d", c),
              {busy, dump_valid, dump_last, done},
              {tv[k].busy, tv[k].valid, tv[k].last, tv[k].done});
          if (tv[k].rr_chk)
            chk($sformatf("tv_rr%0d", c), Dump_Read_Register, tv[k].rr);
        end
      end
    end
    check_beats("nominal", 1);
    chk("nominal_done", dones, 1);

    // Random backpressure with a 5-cycle stall on index 7
    got.delete(); dones = 0; stall_viol = 0;
    held7 = 1'b0; hold = 0;
    pulse_start();
    for (int c = 0; c < 2000 && dones == 0; c++) begin
      if (dump_valid && dump_addr == 5'd7 && !held7) begin
        held7 = 1'b1;
        hold = 5;
      end
      if (hold > 0) begin
        chk("bp_hold7", {dump_valid, dump_addr, dump_data},
            {1'b1, 5'd7, 32'hA5A50007});
        hold--;
        dump_ready = 1'b0;
      end else begin
        dump_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    chk("bp_saw7", held7, 1);
    chk("bp_done", dones, 1);
    chk("bp_stable", stall_viol, 0);
    check_beats("bp", 1);
    dump_ready = 1'b1;
    repeat (3) @(negedge clk);

    // start pulses in FETCH, SEND and DONE are ignored
    got.delete(); dones = 0;
    pulse_start();
    chk("rs_fetch", {busy, dump_valid}, 2'b10);
    start = 1'b1;
    @(negedge clk);
    chk("rs_send", {busy, dump_valid}, 2'b11);
    start = 1'b0;
    for (int c = 3; c <= 65; c++) @(negedge clk);
    chk("rs_donecyc", done, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("rs_idle", {busy, dump_valid, done}, 0);
    chk("rs_dones", dones, 1);
    check_beats("rs", 1);

    // Asynchronous reset while index 12 is waiting in SEND
    got.delete(); dones = 0;
    pulse_start();
    for (int c = 0; c < 200; c++) begin
      if (dump_valid && dump_addr == 5'd12) break;
      @(negedge clk);
    end
    dump_ready = 1'b0;
    chk("rst_pre", {dump_valid, dump_addr}, {1'b1, 5'd12});
    #2 reset = 1'b0;
    #1;
    chk("rst_async", {dump_valid, busy, done, dump_last}, 0);
    chk("rst_regs", {dump_addr, dump_data, Dump_Read_Register}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_nodone", dones, 0);
    chk("rst_partial", 64'(got.size()), 12);
    got.delete(); dones = 0; dump_ready = 1'b1;
    pulse_start();
    repeat (70) @(negedge clk);
    check_beats("rst_after", 1);
    chk("rst_after_done", dones, 1);

    // Live writes while the walk is at index 10
    preload();
    got.delete(); dones = 0; wrote = 1'b0;
    wr_idx[0] = 20; wr_val[0] = 32'hDEADBEEF;
    wr_idx[1] = 3;  wr_val[1] = 32'h12345678;
    pulse_start();
    for (int c = 0; c < 100 && dones == 0; c++) begin
      if (!wrote && dump_valid && dump_addr == 5'd10) begin
        wrote = 1'b1;
        for (int k = 0; k < 2; k++) rf[wr_idx[k]] = wr_val[k];
      end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++)
      if (wr_idx[k] > 10) expv[wr_idx[k]] = wr_val[k];
    chk("wr_done", dones, 1);
    check_beats("wr", 1);

    // start held high: back-to-back dumps
    preload();
    repeat (3) @(negedge clk);
    got.delete(); dones = 0; prev_busy = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (done) done_c.push_back(c);
      if (busy && !prev_busy) rise_c.push_back(c);
      prev_busy = busy;
    end
    start = 1'b0;
    repeat (80) @(negedge clk);
    chk("b2b_ndone", 64'(done_c.size()), 2);
    chk("b2b_nrise", 64'(rise_c.size()), 3);
    if (done_c.size() >= 2 && rise_c.size() >= 3) begin
      chk("b2b_first_done", done_c[0], 65);
      chk("b2b_gap0", rise_c[1], done_c[0] + 2);
      chk("b2b_gap1", rise_c[2], done_c[1] + 2);
    end
    chk("b2b_dones", dones, 3);
    check_beats("b2b", 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
